// File: rtl/vblank_write_sched_if.sv
// Requester handshake and frame-buffer write bus for vblank_write_sched.
// master = requester/frame-buffer side, slave = the scheduler.
interface vblank_write_sched_if #(
  parameter int NREQ = 4,
  parameter int AW   = 11,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fb_we;
  logic [AW-1:0]      fb_addr;
  logic [DW-1:0]      fb_wdata;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, fb_we, fb_addr, fb_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/vblank_write_sched.sv
// Round-robin scheduler that confines frame-buffer writes to vertical blanking,
// with a per-frame write budget and a guard band before the nominal window end.
module vblank_write_sched #(
  parameter int NREQ          = 4,
  parameter int AW            = 11,
  parameter int DW            = 8,
  parameter int WRITE_BUDGET  = 1024,
  parameter int VBLANK_CYCLES = 47040,
  parameter int GUARD_CYCLES  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          curr_y,
  vblank_write_sched_if.slave bus,
  output logic                frame_tick,
  output logic                win_open,
  output logic                overrun
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCW = $clog2(VBLANK_CYCLES + 1);
  localparam int BCW = $clog2(WRITE_BUDGET + 1);

  localparam logic [WCW-1:0]  WIN_LAST = WCW'(VBLANK_CYCLES - GUARD_CYCLES - 1);
  localparam logic [WCW-1:0]  WIN_SAT  = WCW'(VBLANK_CYCLES);
  localparam logic [BCW-1:0]  BUD_MAX  = BCW'(WRITE_BUDGET);
  localparam logic [NREQ-1:0] ONE_HOT  = NREQ'(1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    OPEN   = 2'd1,
    CLOSE  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t          state_r, state_next_s;
  logic            vb_s, vb_q_r, entry_s, exit_s, grant_en_s;
  logic            grant_found_s, xfer_s;
  logic [IW:0]     pick_s;
  logic [IW-1:0]   rr_ptr_r, grant_idx_s;
  logic [NREQ-1:0] ready_s;
  logic [AW-1:0]   sel_addr_s, fb_addr_r;
  logic [DW-1:0]   sel_data_s, fb_wdata_r;
  logic [WCW-1:0]  win_cnt_r;
  logic [BCW-1:0]  budget_cnt_r;
  logic            fb_we_r, frame_tick_r, win_open_r;

  // First valid requester after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid,
                                          input logic [IW-1:0]   ptr);
    logic [IW:0]   res;
    logic [IW-1:0] ci;
    int            cand;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end else begin
        cand = cand;
      end
      ci = IW'(cand);
      if (valid[ci]) begin
        res = {1'b1, ci};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign vb_s    = (curr_y == 10'h3FF);
  assign entry_s = vb_s & ~vb_q_r;
  assign exit_s  = (win_cnt_r == WIN_LAST) || (budget_cnt_r == BUD_MAX) || !vb_s;

  // Arbitration and selected requester's payload.
  always_comb begin
    pick_s        = rr_pick(bus.req_valid, rr_ptr_r);
    grant_found_s = pick_s[IW];
    grant_idx_s   = pick_s[IW-1:0];
    grant_en_s    = (state_r == OPEN) && !exit_s;
    xfer_s        = grant_en_s && grant_found_s;
    ready_s       = xfer_s ? (ONE_HOT << grant_idx_s) : '0;
    sel_addr_s    = bus.req_addr[AW*int'(grant_idx_s) +: AW];
    sel_data_s    = bus.req_data[DW*int'(grant_idx_s) +: DW];
  end

  // Window FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ACTIVE: begin
        if (entry_s) state_next_s = OPEN;
        else         state_next_s = ACTIVE;
      end
      OPEN: begin
        if (exit_s) state_next_s = CLOSE;
        else        state_next_s = OPEN;
      end
      CLOSE: state_next_s = DRAIN;
      DRAIN: begin
        // Budget exhaustion must not re-open the window inside the same blanking.
        if (!vb_s) state_next_s = ACTIVE;
        else       state_next_s = DRAIN;
      end
      default: state_next_s = ACTIVE;
    endcase
  end

  // Blanking edge detector and FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q_r  <= 1'b0;
      state_r <= ACTIVE;
    end else begin
      vb_q_r  <= vb_s;
      state_r <= state_next_s;
    end
  end

  // Saturating window/budget counters and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_r    <= '0;
      budget_cnt_r <= '0;
      rr_ptr_r     <= IW'(NREQ - 1);
    end else begin
      if (state_r == ACTIVE && entry_s) begin
        win_cnt_r <= '0;
      end else if (state_r == OPEN && win_cnt_r != WIN_SAT) begin
        win_cnt_r <= win_cnt_r + WCW'(1);
      end else begin
        win_cnt_r <= win_cnt_r;
      end
      if (state_r == ACTIVE && entry_s) begin
        budget_cnt_r <= '0;
      end else if (xfer_s && budget_cnt_r != BUD_MAX) begin
        budget_cnt_r <= budget_cnt_r + BCW'(1);
      end else begin
        budget_cnt_r <= budget_cnt_r;
      end
      if (xfer_s) rr_ptr_r <= grant_idx_s;
      else        rr_ptr_r <= rr_ptr_r;
    end
  end

  // Frame-buffer write port and status flags, one cycle behind the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we_r      <= 1'b0;
      fb_addr_r    <= '0;
      fb_wdata_r   <= '0;
      frame_tick_r <= 1'b0;
      win_open_r   <= 1'b0;
    end else begin
      fb_we_r <= xfer_s;
      if (xfer_s) begin
        fb_addr_r  <= sel_addr_s;
        fb_wdata_r <= sel_data_s;
      end else begin
        fb_addr_r  <= fb_addr_r;
        fb_wdata_r <= fb_wdata_r;
      end
      frame_tick_r <= (state_r == ACTIVE) && entry_s;
      win_open_r   <= (state_next_s == OPEN);
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.fb_we     = fb_we_r;
  assign bus.fb_addr   = fb_addr_r;
  assign bus.fb_wdata  = fb_wdata_r;
  assign frame_tick    = frame_tick_r;
  assign win_open      = win_open_r;
  assign overrun       = (state_r == CLOSE) && (|bus.req_valid);

endmodule

// File: tb/tb_vblank_write_sched.sv
// Directed bench for vblank_write_sched: a per-cycle vector table plus
// hand-written guard, early-exit, reset and budget sequences.
module tb_vblank_write_sched;

  localparam logic [9:0] YB = 10'h3FF;
  localparam logic [9:0] YA = 10'h000;

  logic       clk;
  logic       rst_n;
  logic [9:0] curr_y;
  logic       frame_tick, win_open, overrun;
  int         n_checks;
  int         n_errors;

  vblank_write_sched_if #(.NREQ(4), .AW(11), .DW(8)) bus ();

  vblank_write_sched #(
    .NREQ(4), .AW(11), .DW(8),
    .WRITE_BUDGET(8), .VBLANK_CYCLES(100), .GUARD_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .curr_y(curr_y), .bus(bus.slave),
    .frame_tick(frame_tick), .win_open(win_open), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0]  y;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic        tick;
    logic        open;
    logic        ovr;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] y, input logic [3:0] v);
    @(negedge clk);
    curr_y = y;
    bus.req_valid = v;
    #1;
  endtask

  initial begin
    int grants, last_grant, we_cnt, close_n, ovr_n, ovr_cnt, tick_cnt;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    curr_y = YA;
    bus.req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*11 +: 11] = 11'h100 + 11'(i);
      bus.req_data[i*8 +: 8]   = 8'hA0 + 8'(i);
    end

    //           y   valid    ready    we    addr     wdata  tick  open  ovr
    vecs[0]  = '{YA, 4'b0001, 4'b0000, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{YA, 4'b0001, 4'b0000, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{YB, 4'b0001, 4'b0000, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{YB, 4'b0001, 4'b0001, 1'b0, 11'h000, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{YB, 4'b1111, 4'b0010, 1'b1, 11'h100, 8'hA0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{YB, 4'b1111, 4'b0100, 1'b1, 11'h101, 8'hA1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{YB, 4'b1111, 4'b1000, 1'b1, 11'h102, 8'hA2, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{YB, 4'b1111, 4'b0001, 1'b1, 11'h103, 8'hA3, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{YB, 4'b1111, 4'b0010, 1'b1, 11'h100, 8'hA0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{YB, 4'b1111, 4'b0100, 1'b1, 11'h101, 8'hA1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{YB, 4'b1111, 4'b1000, 1'b1, 11'h102, 8'hA2, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{YB, 4'b1111, 4'b0000, 1'b1, 11'h103, 8'hA3, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{YB, 4'b1111, 4'b0000, 1'b0, 11'h103, 8'hA3, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{YB, 4'b1111, 4'b0000, 1'b0, 11'h103, 8'hA3, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{YA, 4'b0000, 4'b0000, 1'b0, 11'h103, 8'hA3, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{YB, 4'b0000, 4'b0000, 1'b0, 11'h103, 8'hA3, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{YB, 4'b0000, 4'b0000, 1'b0, 11'h103, 8'hA3, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{YB, 4'b0010, 4'b0010, 1'b0, 11'h103, 8'hA3, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{YA, 4'b0010, 4'b0000, 1'b1, 11'h101, 8'hA1, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{YA, 4'b0010, 4'b0000, 1'b0, 11'h101, 8'hA1, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{YA, 4'b0000, 4'b0000, 1'b0, 11'h101, 8'hA1, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{YA, 4'b0000, 4'b0000, 1'b0, 11'h101, 8'hA1, 1'b0, 1'b0, 1'b0};

    // Reset state.
    #12;
    chk("rst ready", 32'(bus.req_ready), 32'h0);
    chk("rst fb_we", 32'(bus.fb_we), 32'h0);
    chk("rst fb_addr", 32'(bus.fb_addr), 32'h0);
    chk("rst fb_wdata", 32'(bus.fb_wdata), 32'h0);
    chk("rst tick/open/ovr", {29'd0, frame_tick, win_open, overrun}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness, budget, glitch re-entry and early exit via the vector table.
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].y, vecs[i].valid);
      chk($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
      chk($sformatf("v%0d fb_we", i), 32'(bus.fb_we), 32'(vecs[i].we));
      chk($sformatf("v%0d fb_addr", i), 32'(bus.fb_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d fb_wdata", i), 32'(bus.fb_wdata), 32'(vecs[i].wdata));
      chk($sformatf("v%0d frame_tick", i), 32'(frame_tick), 32'(vecs[i].tick));
      chk($sformatf("v%0d win_open", i), 32'(win_open), 32'(vecs[i].open));
      chk($sformatf("v%0d overrun", i), 32'(overrun), 32'(vecs[i].ovr));
    end

    // Guard band: window closes when win_cnt reaches 100-16-1 = 83.
    step(YB, 4'b0000);
    grants = 0; last_grant = -1; we_cnt = 0; close_n = -1; ovr_n = -1;
    for (int n = 0; n < 86; n++) begin
      step(YB, (n >= 79) ? 4'b0001 : 4'b0000);
      if (n == 0) chk("guard frame_tick", 32'(frame_tick), 32'h1);
      if (bus.req_ready != 4'b0000) begin
        grants++;
        last_grant = n;
      end
      if (bus.fb_we) we_cnt++;
      if (!win_open && close_n < 0) close_n = n;
      if (overrun) ovr_n = n;
    end
    chk("guard grants", 32'(grants), 32'd4);
    chk("guard last grant", 32'(last_grant), 32'd82);
    chk("guard fb_we count", 32'(we_cnt), 32'd4);
    chk("guard win_open fall", 32'(close_n), 32'd84);
    chk("guard overrun cycle", 32'(ovr_n), 32'd84);
    step(YA, 4'b0000);
    step(YA, 4'b0000);

    // Early exit after 20 window cycles; a valid in the exit cycle is not granted.
    step(YB, 4'b0000);
    for (int n = 0; n < 20; n++) step(YB, 4'b0000);
    step(YA, 4'b1000);
    chk("early exit win_open", 32'(win_open), 32'h1);
    chk("early exit no grant", 32'(bus.req_ready), 32'h0);
    step(YA, 4'b0000);
    chk("early close win_open", 32'(win_open), 32'h0);
    chk("early close overrun", 32'(overrun), 32'h0);
    step(YA, 4'b0000);
    step(YA, 4'b0000);

    // Asynchronous reset in the middle of an open window.
    step(YB, 4'b0000);
    step(YB, 4'b1111);
    step(YB, 4'b1111);
    chk("pre-reset ready", 32'(bus.req_ready != 4'b0000), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst ready", 32'(bus.req_ready), 32'h0);
    chk("mid rst fb_we", 32'(bus.fb_we), 32'h0);
    chk("mid rst win_open", 32'(win_open), 32'h0);
    chk("mid rst overrun", 32'(overrun), 32'h0);
    curr_y = YA;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(YA, 4'b1111);
    step(YB, 4'b1111);
    chk("post-rst no early grant", 32'(bus.req_ready), 32'h0);
    step(YB, 4'b1111);
    chk("post-rst first grant", 32'(bus.req_ready), 32'b0001);
    chk("post-rst frame_tick", 32'(frame_tick), 32'h1);
    step(YA, 4'b0000);
    step(YA, 4'b0000);
    step(YA, 4'b0000);
    step(YA, 4'b0000);

    // Budget: requester 2 always valid, blanking held long.
    step(YB, 4'b0100);
    grants = 0; we_cnt = 0; ovr_cnt = 0; tick_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      step(YB, 4'b0100);
      if (bus.req_ready != 4'b0000) grants++;
      if (bus.fb_we) begin
        we_cnt++;
        chk("budget fb_addr", 32'(bus.fb_addr), 32'h102);
      end
      if (overrun) ovr_cnt++;
      if (frame_tick) tick_cnt++;
    end
    chk("budget grants", 32'(grants), 32'd8);
    chk("budget fb_we count", 32'(we_cnt), 32'd8);
    chk("budget overrun count", 32'(ovr_cnt), 32'd1);
    chk("budget frame_tick count", 32'(tick_cnt), 32'd1);
    chk("budget window closed", 32'(win_open), 32'h0);
    step(YA, 4'b0000);
    step(YA, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
